// File: rtl/fpga_pkg.sv
// ---------------------------------------------------------------------------
// fpga_pkg
//
// Shared AXI-Lite definitions for the FPGA codebase: the request/response
// structs used by AXI-Lite slaves, the response codes, and a helper that
// evaluates the privileged/secure protection qualifiers of an access.
//
// Contents:
//   AXI_LITE_ADDR_W / AXI_LITE_DATA_W  default struct field widths
//   axi_resp_t, RESP_OKAY, RESP_SLVERR response type and codes
//   axi_lite_req_t                     master -> slave (AW, W, B ready, AR, R ready)
//   axi_lite_resp_t                    slave -> master (AW/W/AR ready, B, R)
//   prot_ok()                          protection qualifier check
// ---------------------------------------------------------------------------
package fpga_pkg;

  localparam int unsigned AXI_LITE_ADDR_W = 32;
  localparam int unsigned AXI_LITE_DATA_W = 32;
  localparam int unsigned AXI_LITE_STRB_W = AXI_LITE_DATA_W / 8;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_LITE_ADDR_W-1:0] aw_addr;
    logic [2:0]                 aw_prot;
    logic                       aw_valid;
    logic [AXI_LITE_DATA_W-1:0] w_data;
    logic [AXI_LITE_STRB_W-1:0] w_strb;
    logic                       w_valid;
    logic                       b_ready;
    logic [AXI_LITE_ADDR_W-1:0] ar_addr;
    logic [2:0]                 ar_prot;
    logic                       ar_valid;
    logic                       r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic                       aw_ready;
    logic                       w_ready;
    axi_resp_t                  b_resp;
    logic                       b_valid;
    logic                       ar_ready;
    logic [AXI_LITE_DATA_W-1:0] r_data;
    axi_resp_t                  r_resp;
    logic                       r_valid;
  } axi_lite_resp_t;

  // prot[0] set marks a privileged access, prot[1] clear marks a secure one.
  function automatic logic prot_ok(input logic [2:0] prot,
                                   input logic       priv_only,
                                   input logic       secu_only);
    return (!priv_only || prot[0]) && (!secu_only || !prot[1]);
  endfunction

endpackage

// File: rtl/axi_lite_regfile_chan_reg.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile_chan_reg
//
// One-entry valid/ready output register used for the B and R channels of the
// register file. A new beat is accepted while the register is empty or is
// being drained in the same cycle, so back-to-back responses run at full rate.
// Payload is held stable while out_valid is high and out_ready is low.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (drops any held beat)
//   in_valid   producer has a beat to store
//   in_ready   register can take a beat this cycle
//   in_data    beat payload
//   out_valid  beat held for the consumer
//   out_ready  consumer takes the held beat
//   out_data   held payload
// ---------------------------------------------------------------------------
module axi_lite_regfile_chan_reg #(
  parameter int unsigned DataWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data
);

  logic                 valid_reg;
  logic [DataWidth-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      data_reg  <= in_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
//
// AXI-Lite slave exposing RegNumBytes byte registers. Byte i lives at byte
// address i; accesses are word based (AxiDataWidth/8 bytes, address aligned
// down). Individual bytes may be read-only over AXI, and every byte can be
// loaded from the fabric side through reg_load_i/reg_d_i, which wins over AXI
// writes: a write touching a byte being loaded is held off until the load
// bit drops.
//
// Optional feature: define AXI_LITE_REGFILE_PROT_CHECK_EN to enforce the
// PrivProtOnly / SecuProtOnly qualifiers (failing accesses answer SLVERR).
// Without the macro the prot fields are ignored.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   axi_req_i    AXI-Lite request struct
//   axi_resp_o   AXI-Lite response struct
//   wr_active_o  per byte, high in the cycle an AXI write updates the byte
//   rd_active_o  per byte, high in the cycle an AXI read samples the byte
//   reg_d_i      fabric load data, one byte per register
//   reg_load_i   fabric load strobe, one bit per register
//   reg_q_o      current register contents
// ---------------------------------------------------------------------------
module axi_lite_regfile
  import fpga_pkg::*;
#(
  parameter int unsigned              RegNumBytes  = 32,
  parameter int unsigned              AxiAddrWidth = 32,
  parameter int unsigned              AxiDataWidth = 32,
  parameter logic [RegNumBytes-1:0]   AxiReadOnly  = '0,
  parameter logic [RegNumBytes*8-1:0] RegRstVal    = '0,
  parameter bit                       PrivProtOnly = 1'b0,
  parameter bit                       SecuProtOnly = 1'b0,
  parameter type                      req_lite_t   = axi_lite_req_t,
  parameter type                      resp_lite_t  = axi_lite_resp_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  req_lite_t                    axi_req_i,
  output resp_lite_t                   axi_resp_o,
  output logic [RegNumBytes-1:0]       wr_active_o,
  output logic [RegNumBytes-1:0]       rd_active_o,
  input  logic [RegNumBytes-1:0][7:0]  reg_d_i,
  input  logic [RegNumBytes-1:0]       reg_load_i,
  output logic [RegNumBytes-1:0][7:0]  reg_q_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned AddrShift = $clog2(StrbWidth);
  localparam int unsigned WordIdxW  = AxiAddrWidth - AddrShift;
  localparam int unsigned NumWords  = (RegNumBytes + StrbWidth - 1) / StrbWidth;
  localparam int unsigned RDataW    = AxiDataWidth + 2;

  typedef logic [WordIdxW-1:0] word_idx_t;

  // Handshakes are held off until the first edge after reset release so that
  // ready stays low for the whole reset interval.
  logic                          out_en_reg;
  logic [RegNumBytes-1:0][7:0]   reg_q_reg;

  // -------------------------------------------------------------------------
  // Protection check
  // -------------------------------------------------------------------------
  logic aw_prot_fail;
  logic ar_prot_fail;

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
  assign aw_prot_fail = !prot_ok(axi_req_i.aw_prot, PrivProtOnly, SecuProtOnly);
  assign ar_prot_fail = !prot_ok(axi_req_i.ar_prot, PrivProtOnly, SecuProtOnly);
`else
  assign aw_prot_fail = 1'b0;
  assign ar_prot_fail = 1'b0;
  logic unused_prot;
  assign unused_prot = ^{axi_req_i.aw_prot, axi_req_i.ar_prot, PrivProtOnly, SecuProtOnly};
`endif

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  word_idx_t               aw_word;
  logic [StrbWidth-1:0]    w_strb;
  logic [AxiDataWidth-1:0] w_data;
  logic                    aw_in_range;
  logic [RegNumBytes-1:0]  wr_sel;
  logic [RegNumBytes-1:0]  wr_en;
  logic                    wr_any_writable;
  logic                    wr_err;
  logic                    wr_stall;
  logic                    wr_req;
  logic                    wr_hs;
  logic                    b_in_ready;
  logic                    b_valid;
  axi_resp_t               b_resp;

  assign aw_word     = axi_req_i.aw_addr[AxiAddrWidth-1:AddrShift];
  assign w_strb      = axi_req_i.w_strb;
  assign w_data      = axi_req_i.w_data;
  assign aw_in_range = (aw_word < word_idx_t'(NumWords));

  // A byte is selected when its word is addressed and its lane is strobed;
  // bytes past RegNumBytes simply have no entry here.
  for (genvar gi = 0; gi < RegNumBytes; gi++) begin : g_wr_dec
    localparam int unsigned Lane = gi % StrbWidth;
    localparam int unsigned Word = gi / StrbWidth;
    assign wr_sel[gi] = (aw_word == word_idx_t'(Word)) && w_strb[Lane];
  end

  assign wr_any_writable = |(wr_sel & ~AxiReadOnly);

  // Any strobed lane that cannot be written (read-only or past the end of
  // the register space) counts toward the all-read-only error.
  assign wr_err = !aw_in_range || aw_prot_fail || ((|w_strb) && !wr_any_writable);

  assign wr_stall = |(wr_sel & reg_load_i);
  assign wr_req   = out_en_reg && axi_req_i.aw_valid && axi_req_i.w_valid && !wr_stall;
  assign wr_hs    = wr_req && b_in_ready;
  assign wr_en    = {RegNumBytes{wr_hs && !wr_err}} & wr_sel & ~AxiReadOnly;

  assign wr_active_o = wr_en;

  axi_lite_regfile_chan_reg #(
    .DataWidth (2)
  ) u_b_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (wr_req),
    .in_ready  (b_in_ready),
    .in_data   (wr_err ? RESP_SLVERR : RESP_OKAY),
    .out_valid (b_valid),
    .out_ready (axi_req_i.b_ready),
    .out_data  (b_resp)
  );

  // -------------------------------------------------------------------------
  // Read decode
  // -------------------------------------------------------------------------
  word_idx_t                            ar_word;
  logic                                 ar_in_range;
  logic                                 rd_err;
  logic                                 rd_req;
  logic                                 rd_hs;
  logic                                 r_in_ready;
  logic [RegNumBytes-1:0]               rd_sel;
  logic [NumWords*StrbWidth-1:0][7:0]   reg_pad;
  logic [AxiDataWidth-1:0]              rd_word_data;
  logic [RDataW-1:0]                    r_in_data;
  logic [RDataW-1:0]                    r_out_data;
  logic                                 r_valid;

  assign ar_word     = axi_req_i.ar_addr[AxiAddrWidth-1:AddrShift];
  assign ar_in_range = (ar_word < word_idx_t'(NumWords));
  assign rd_err      = !ar_in_range || ar_prot_fail;
  assign rd_req      = out_en_reg && axi_req_i.ar_valid;
  assign rd_hs       = rd_req && r_in_ready;

  for (genvar gi = 0; gi < RegNumBytes; gi++) begin : g_rd_dec
    localparam int unsigned Word = gi / StrbWidth;
    assign rd_sel[gi] = (ar_word == word_idx_t'(Word));
  end

  assign rd_active_o = {RegNumBytes{rd_hs && !rd_err}} & rd_sel;

  // Pad the register space up to whole words; the padding reads as zero.
  for (genvar gi = 0; gi < NumWords * StrbWidth; gi++) begin : g_pad
    if (gi < RegNumBytes) begin : g_reg
      assign reg_pad[gi] = reg_q_reg[gi];
    end else begin : g_zero
      assign reg_pad[gi] = 8'h00;
    end
  end

  always_comb begin
    rd_word_data = '0;
    for (int unsigned w = 0; w < NumWords; w++) begin
      if (ar_word == word_idx_t'(w)) begin
        rd_word_data = reg_pad[w*StrbWidth +: StrbWidth];
      end
    end
  end

  // Data is sampled from the register state before this edge's updates, so
  // a same-cycle write or load is not visible to the read.
  assign r_in_data = rd_err ? {RESP_SLVERR, {AxiDataWidth{1'b0}}}
                            : {RESP_OKAY, rd_word_data};

  axi_lite_regfile_chan_reg #(
    .DataWidth (RDataW)
  ) u_r_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (rd_req),
    .in_ready  (r_in_ready),
    .in_data   (r_in_data),
    .out_valid (r_valid),
    .out_ready (axi_req_i.r_ready),
    .out_data  (r_out_data)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_en_reg <= 1'b0;
    end else begin
      out_en_reg <= 1'b1;
    end
  end

  // Fabric loads take priority; a conflicting AXI write never handshakes,
  // so the else-branch only sees bytes without a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q_reg <= RegRstVal;
    end else begin
      for (int unsigned i = 0; i < RegNumBytes; i++) begin
        if (reg_load_i[i]) begin
          reg_q_reg[i] <= reg_d_i[i];
        end else if (wr_en[i]) begin
          reg_q_reg[i] <= w_data[(i % StrbWidth)*8 +: 8];
        end
      end
    end
  end

  assign reg_q_o = reg_q_reg;

  // -------------------------------------------------------------------------
  // Response assembly
  // -------------------------------------------------------------------------
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = wr_hs;
    axi_resp_o.w_ready  = wr_hs;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b_resp   = b_resp;
    axi_resp_o.ar_ready = rd_hs;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r_resp   = r_out_data[RDataW-1 -: 2];
    axi_resp_o.r_data   = r_out_data[AxiDataWidth-1:0];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile
//
// Bench for axi_lite_regfile with 32 byte registers on a 32-bit bus; byte 5
// resets to 0x60, byte 20 to 0x40, and byte 1 is read-only so the read-only
// rules can be exercised. A byte-array model of the register file checks every
// output on every falling edge; directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile;
  import fpga_pkg::*;

  localparam int NB = 32;
  localparam logic [NB-1:0]   RO_MASK = 32'h0000_0002;
  localparam logic [NB*8-1:0] RST_VAL = (256'h40 << (20*8)) | (256'h60 << (5*8));

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  axi_lite_req_t             req;
  axi_lite_resp_t            resp;
  logic [NB-1:0]             wr_active;
  logic [NB-1:0]             rd_active;
  logic [NB-1:0][7:0]        reg_d;
  logic [NB-1:0]             reg_load;
  logic [NB-1:0][7:0]        reg_q;

  always #5 clk_i = ~clk_i;

  axi_lite_regfile #(
    .RegNumBytes  (NB),
    .AxiAddrWidth (32),
    .AxiDataWidth (32),
    .AxiReadOnly  (RO_MASK),
    .RegRstVal    (RST_VAL),
    .PrivProtOnly (1'b1),
    .SecuProtOnly (1'b0),
    .req_lite_t   (axi_lite_req_t),
    .resp_lite_t  (axi_lite_resp_t)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .axi_req_i   (req),
    .axi_resp_o  (resp),
    .wr_active_o (wr_active),
    .rd_active_o (rd_active),
    .reg_d_i     (reg_d),
    .reg_load_i  (reg_load),
    .reg_q_o     (reg_q)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: byte array plus one pending B and R response.
  // ------------------------------------------------------------------------
  logic [7:0]  m_mem [NB];
  logic        m_bp;
  logic [1:0]  m_br;
  logic        m_rp;
  logic [31:0] m_rd;
  logic [1:0]  m_rr;

  always @(negedge clk_i) begin : model
    int            aw_w, ar_w;
    logic          aw_in, ar_in, conflict, exp_aw, exp_ar, werr, rerr, pf_w, pf_r;
    logic [NB-1:0] sel, exp_wact, exp_ract;
    logic [31:0]   rd;
    logic [255:0]  mem_flat;
    if (!rst_ni) begin
      for (int i = 0; i < NB; i++) m_mem[i] = RST_VAL[i*8 +: 8];
      m_bp = 1'b0;
      m_rp = 1'b0;
      chk("rst_reg_q", reg_q, RST_VAL);
      chk("rst_ready", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 0);
      chk("rst_valid", {resp.b_valid, resp.r_valid}, 0);
      chk("rst_active", {wr_active, rd_active}, 0);
    end else begin
`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
      pf_w = !req.aw_prot[0];
      pf_r = !req.ar_prot[0];
`else
      pf_w = 1'b0;
      pf_r = 1'b0;
`endif
      // write side
      aw_w  = int'(req.aw_addr >> 2);
      aw_in = aw_w < NB / 4;
      sel   = '0;
      if (aw_in) for (int j = 0; j < 4; j++) if (req.w_strb[j]) sel[aw_w*4 + j] = 1'b1;
      conflict = |(sel & reg_load);
      exp_aw   = req.aw_valid && req.w_valid && (!m_bp || req.b_ready) && !conflict;
      werr     = !aw_in || pf_w || ((req.w_strb != 4'h0) && ((sel & ~RO_MASK) == '0));
      exp_wact = (exp_aw && !werr) ? (sel & ~RO_MASK) : '0;
      // read side
      ar_w     = int'(req.ar_addr >> 2);
      ar_in    = ar_w < NB / 4;
      rerr     = !ar_in || pf_r;
      exp_ar   = req.ar_valid && (!m_rp || req.r_ready);
      exp_ract = '0;
      rd       = '0;
      if (!rerr) for (int j = 0; j < 4; j++) rd[j*8 +: 8] = m_mem[ar_w*4 + j];
      if (exp_ar && !rerr) for (int j = 0; j < 4; j++) exp_ract[ar_w*4 + j] = 1'b1;
      for (int i = 0; i < NB; i++) mem_flat[i*8 +: 8] = m_mem[i];

      chk("ready", {resp.aw_ready, resp.w_ready, resp.ar_ready}, {exp_aw, exp_aw, exp_ar});
      chk("wr_active", wr_active, exp_wact);
      chk("rd_active", rd_active, exp_ract);
      chk("b_chan", {resp.b_valid, resp.b_valid ? resp.b_resp : 2'b00},
                    {m_bp, m_bp ? m_br : 2'b00});
      chk("r_chan", {resp.r_valid, resp.r_valid ? {resp.r_resp, resp.r_data} : 34'h0},
                    {m_rp, m_rp ? {m_rr, m_rd} : 34'h0});
      chk("reg_q", reg_q, mem_flat);

      // advance to the state after the coming edge
      if (exp_aw) begin
        m_bp = 1'b1;
        m_br = werr ? RESP_SLVERR : RESP_OKAY;
      end else if (req.b_ready) begin
        m_bp = 1'b0;
      end
      if (exp_ar) begin
        m_rp = 1'b1;
        m_rd = rd;
        m_rr = rerr ? RESP_SLVERR : RESP_OKAY;
      end else if (req.r_ready) begin
        m_rp = 1'b0;
      end
      for (int i = 0; i < NB; i++) begin
        if (reg_load[i]) m_mem[i] = reg_d[i];
        else if (exp_wact[i]) m_mem[i] = req.w_data[(i % 4)*8 +: 8];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Directed transaction helpers (bounded waits)
  // ------------------------------------------------------------------------
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [NB-1:0] wact);
    int n;
    @(posedge clk_i); #1;
    req.aw_addr = a; req.w_data = d; req.w_strb = s;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.aw_ready) break;
    end
    chk("wr_hs_bound", n < 40, 1);
    wact = wr_active;
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
  endtask

  task automatic wr_resp(output logic [1:0] r);
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.b_valid && req.b_ready) break;
    end
    chk("b_bound", n < 40, 1);
    r = resp.b_resp;
  endtask

  task automatic rd_issue(input logic [31:0] a, output logic [NB-1:0] ract);
    int n;
    @(posedge clk_i); #1;
    req.ar_addr = a; req.ar_valid = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.ar_ready) break;
    end
    chk("rd_hs_bound", n < 40, 1);
    ract = rd_active;
    @(posedge clk_i); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic rd_resp(output logic [31:0] d, output logic [1:0] r);
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.r_valid && req.r_ready) break;
    end
    chk("r_bound", n < 40, 1);
    d = resp.r_data;
    r = resp.r_resp;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin : stim
    logic [NB-1:0]       act;
    logic [1:0]          br, rr;
    logic [31:0]         rdat;
    logic [NB-1:0][7:0]  snap;
    logic                aw_acc, ar_acc;
    int                  n;

    req = '0;
    reg_load = '0;
    reg_d = '0;
    // valids high during reset: readies must stay low
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1; req.w_strb = 4'hF;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_byte5", reg_q[5], 8'h60);
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // reset values via AXI reads
    rd_issue(32'h04, act);
    chk("rd04_active", act, 32'h0000_00F0);
    rd_resp(rdat, rr);
    chk("rd04_data", {rr, rdat}, {RESP_OKAY, 32'h0000_6000});
    rd_issue(32'h14, act);
    rd_resp(rdat, rr);
    chk("rd14_data", {rr, rdat}, {RESP_OKAY, 32'h0000_0040});

    // single byte write
    wr_issue(32'h00, 32'h0000_0041, 4'b0001, act);
    chk("wr00_active", act, 32'h1);
    chk("wr00_byte0", reg_q[0], 8'h41);
    wr_resp(br);
    chk("wr00_resp", br, RESP_OKAY);

    // out of range write and read
    snap = reg_q;
    wr_issue(32'h20, 32'hDEAD_BEEF, 4'hF, act);
    chk("wr20_active", act, 0);
    wr_resp(br);
    chk("wr20_resp", br, RESP_SLVERR);
    chk("wr20_nochange", reg_q, snap);
    rd_issue(32'h20, act);
    chk("rd20_active", act, 0);
    rd_resp(rdat, rr);
    chk("rd20_data", {rr, rdat}, {RESP_SLVERR, 32'h0});

    // read-only byte 1
    wr_issue(32'h00, 32'h0000_AABB, 4'b0011, act);
    wr_resp(br);
    chk("ro_resp", br, RESP_OKAY);
    chk("ro_bytes", {reg_q[1], reg_q[0]}, 16'h00BB);
    wr_issue(32'h00, 32'h0000_CC00, 4'b0010, act);
    wr_resp(br);
    chk("ro_only_resp", br, RESP_SLVERR);
    chk("ro_only_byte1", reg_q[1], 8'h00);

    // backpressure: responses must hold and no new write may be taken
    @(posedge clk_i); #1;
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    wr_issue(32'h08, 32'h1234_5678, 4'hF, act);
    rd_issue(32'h04, act);
    @(posedge clk_i); #1;
    req.aw_addr = 32'h10; req.w_data = 32'hCAFE_F00D; req.w_strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      chk("hold_b", {resp.b_valid, resp.b_resp}, {1'b1, RESP_OKAY});
      chk("hold_r", {resp.r_valid, resp.r_resp, resp.r_data}, {1'b1, RESP_OKAY, 32'h0000_6000});
      chk("hold_no_aw", resp.aw_ready, 0);
    end
    @(posedge clk_i); #1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.aw_ready) break;
    end
    chk("hold_release_bound", n < 40, 1);
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    wr_resp(br);
    chk("hold_second_resp", br, RESP_OKAY);
    chk("hold_second_data", {reg_q[19], reg_q[18], reg_q[17], reg_q[16]}, 32'hCAFE_F00D);

    // fabric load colliding with an AXI write to byte 0
    @(posedge clk_i); #1;
    reg_load[0] = 1'b1; reg_d[0] = 8'h55;
    req.aw_addr = 32'h00; req.w_data = 32'h0000_0077; req.w_strb = 4'b0001;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("load_stall", resp.aw_ready, 0);
    end
    chk("load_byte0", reg_q[0], 8'h55);
    @(posedge clk_i); #1;
    reg_load[0] = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (resp.aw_ready) break;
    end
    chk("load_release_bound", n < 40, 1);
    @(posedge clk_i); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    chk("load_then_write", reg_q[0], 8'h77);
    wr_resp(br);

    // randomized traffic, model checks every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      aw_acc = req.aw_valid && resp.aw_ready;
      ar_acc = req.ar_valid && resp.ar_ready;
      @(posedge clk_i); #1;
      if (!req.aw_valid || aw_acc) begin
        req.aw_valid = ($urandom_range(0, 2) != 0);
        req.w_valid  = req.aw_valid;
        req.aw_addr  = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
        req.aw_prot  = 3'($urandom_range(0, 7));
        req.w_strb   = 4'($urandom_range(1, 15));
        req.w_data   = $urandom;
      end
      if (!req.ar_valid || ar_acc) begin
        req.ar_valid = ($urandom_range(0, 2) != 0);
        req.ar_addr  = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
        req.ar_prot  = 3'($urandom_range(0, 7));
      end
      req.b_ready = ($urandom_range(0, 3) != 0);
      req.r_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NB; i++) begin
        reg_load[i] = (i < 12) && ($urandom_range(0, 7) == 0);
        reg_d[i]    = 8'($urandom);
      end
    end
    // let outstanding requests complete
    reg_load = '0;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    for (n = 0; n < 50 && (req.aw_valid || req.ar_valid); n++) begin
      @(negedge clk_i);
      aw_acc = req.aw_valid && resp.aw_ready;
      ar_acc = req.ar_valid && resp.ar_ready;
      @(posedge clk_i); #1;
      if (aw_acc) begin req.aw_valid = 1'b0; req.w_valid = 1'b0; end
      if (ar_acc) req.ar_valid = 1'b0;
    end
    chk("drain_bound", n < 50, 1);
    repeat (3) @(posedge clk_i);

    // reset in the middle of pending responses
    #1;
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    wr_issue(32'h00, 32'h0000_0099, 4'b0001, act);
    rd_issue(32'h04, act);
    @(negedge clk_i);
    chk("pre_rst_pending", {resp.b_valid, resp.r_valid}, 2'b11);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_drop", {resp.b_valid, resp.r_valid}, 2'b00);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_no_resp", {resp.b_valid, resp.r_valid}, 2'b00);
    end
    chk("post_rst_regs", reg_q, RST_VAL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
